// File: rtl/loom_clkgen_if.sv
// loom_clkgen_if
//   Configuration handshake and clock outputs of the clock-generator model.
//   master : whoever programs the divider and requests channel enables
//   slave  : the clock-generator model
//   cfg_valid/cfg_ready : divide-ratio write handshake
//   cfg_ch / cfg_div    : target channel and new ratio (0 behaves as 1)
//   ce                  : per-channel enable request
//   locked              : outputs valid and stable
//   clk_en / clk_div    : per-channel enable pulse and divided clock level
interface loom_clkgen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] ce;
  logic              locked;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] clk_div;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, ce,
    input  cfg_ready, locked, clk_en, clk_div
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, ce,
    output cfg_ready, locked, clk_en, clk_div
  );
endinterface

// File: rtl/loom_clkgen_model.sv
// loom_clkgen_model
//   Behavioural clock generator for simulation builds. Produces NUM_CH divided
//   clock levels and matching one-cycle enable pulses from clk, with runtime
//   divide ratios, glitch-free per-channel gating and a modelled lock delay.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : loom_clkgen_if slave (cfg handshake, ce requests, clock outputs)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   LOCKING  | lock delay running; phase counters held at 0, no outputs
//   LOCKED   | outputs live; accepts one cfg write, which forces a relock
module loom_clkgen_model #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  loom_clkgen_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LCW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic {LOCKING, LOCKED} state_t;

  state_t            state;
  logic [LCW-1:0]    lock_cnt;
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] ce_q;

  logic              locked;
  logic              ch_ok;
  logic              wr_en;
  logic [DIV_W-1:0]  wr_div;
  logic [DIV_W-1:0]  div_m1 [NUM_CH];
  logic [DIV_W:0]    half   [NUM_CH];
  logic [NUM_CH-1:0] at_end;
  logic [NUM_CH-1:0] en_c;
  logic [NUM_CH-1:0] div_c;

  assign locked = (state == LOCKED);
  // Out-of-range channels still complete the handshake but change nothing.
  assign ch_ok  = (int'(bus.cfg_ch) < NUM_CH);
  assign wr_en  = bus.cfg_valid && locked && ch_ok;
  assign wr_div = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;

  always_comb begin
    at_end = '0;
    en_c   = '0;
    div_c  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      div_m1[ch] = div_q[ch] - DIV_W'(1);
      // ceil(div/2), one bit wider so div = 2^DIV_W-1 does not overflow
      half[ch]   = ({1'b0, div_q[ch]} + (DIV_W+1)'(1)) >> 1;
      at_end[ch] = (cnt_q[ch] == div_m1[ch]);
      en_c[ch]   = locked && ce_q[ch] && at_end[ch];
      div_c[ch]  = locked && ce_q[ch] && ({1'b0, cnt_q[ch]} < half[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      ce_q     <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        div_q[ch] <= DIV_W'(1);
        cnt_q[ch] <= '0;
      end
    end else begin
      case (state)
        LOCKING: begin
          lock_cnt <= lock_cnt + LCW'(1);
          ce_q     <= bus.ce;
          for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
          if (lock_cnt == LOCK_LAST) state <= LOCKED;
        end
        LOCKED: begin
          // Enables only move at a period boundary so a level is never cut short.
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if (at_end[ch]) begin
              ce_q[ch]  <= bus.ce[ch];
              cnt_q[ch] <= '0;
            end else begin
              cnt_q[ch] <= cnt_q[ch] + DIV_W'(1);
            end
          end
          // A write overrides the counter advance; the boundary ce sample above stays.
          if (wr_en) begin
            state    <= LOCKING;
            lock_cnt <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
              cnt_q[ch] <= '0;
              if (bus.cfg_ch == CH_W'(ch)) div_q[ch] <= wr_div;
            end
          end
        end
        default: state <= LOCKING;
      endcase
    end
  end

  assign bus.locked    = locked;
  assign bus.cfg_ready = locked;
  assign bus.clk_en    = en_c;
  assign bus.clk_div   = div_c;

endmodule

// File: tb/tb_loom_clkgen_model.sv
module tb_loom_clkgen_model;
  localparam int NC = 3;
  localparam int DW = 8;
  localparam int LC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loom_clkgen_if #(.NUM_CH(NC), .DIV_W(DW)) bus ();

  loom_clkgen_model #(.NUM_CH(NC), .DIV_W(DW), .LOCK_CYCLES(LC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Advance one cycle; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int dv, output int wait_c, output int relock_c);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = 8'(dv);
    wait_c = 0;
    while (!bus.cfg_ready && wait_c < 100) begin
      tick();
      wait_c++;
    end
    tick();
    bus.cfg_valid = 1'b0;
    relock_c = 0;
    while (!bus.locked && relock_c < 100) begin
      tick();
      relock_c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_div = '0;
    bus.ce = '1;
    tick();
    tick();
    vectors++;
    if ({bus.locked, bus.cfg_ready, bus.clk_en, bus.clk_div} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {bus.locked, bus.cfg_ready, bus.clk_en, bus.clk_div});
    end
    rst = 1'b0;
    for (int k = 0; k < LC; k++) begin
      vectors++;
      if (bus.locked !== 1'b0 || bus.clk_en !== 3'b000) begin
        miscompares++;
        $display("FAIL lock_delay cycle %0d: locked %b clk_en %b expected 0 000", k, bus.locked, bus.clk_en);
      end
      tick();
    end
    vectors++;
    if ({bus.locked, bus.cfg_ready, bus.clk_en, bus.clk_div} !== 8'hFF) begin
      miscompares++;
      $display("FAIL first_lock: got %b expected 11111111",
               {bus.locked, bus.cfg_ready, bus.clk_en, bus.clk_div});
    end
  endtask

  task automatic test_cfg_div();
    int w, r;
    logic [NC-1:0] ee, ed;
    write_cfg(1, 4, w, r);
    vectors++;
    if (r !== LC) begin miscompares++; $display("FAIL relock_ch1: got %0d expected %0d", r, LC); end
    write_cfg(2, 5, w, r);
    vectors++;
    if (w !== 0 || r !== LC) begin
      miscompares++;
      $display("FAIL relock_ch2: wait %0d relock %0d expected 0 %0d", w, r, LC);
    end
    for (int t = 0; t < 20; t++) begin
      ee = {t % 5 == 4, t % 4 == 3, 1'b1};
      ed = {t % 5 < 3,  t % 4 < 2,  1'b1};
      vectors++;
      if (bus.clk_en !== ee || bus.clk_div !== ed) begin
        miscompares++;
        $display("FAIL div_pattern t=%0d: en %b div %b expected en %b div %b", t, bus.clk_en, bus.clk_div, ee, ed);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int w, r;
    logic [NC-1:0] ee, ed;
    write_cfg(0, 0, w, r);
    vectors++;
    if (r !== LC) begin miscompares++; $display("FAIL relock_div0: got %0d expected %0d", r, LC); end
    for (int t = 0; t < 13; t++) begin
      if (t == 3) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_ch = 2'(NC);
        bus.cfg_div = 8'd7;
        vectors++;
        if (bus.cfg_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL noop_ready: got %b expected 1", bus.cfg_ready);
        end
      end
      if (t == 4) bus.cfg_valid = 1'b0;
      ee = {t % 5 == 4, t % 4 == 3, 1'b1};
      ed = {t % 5 < 3,  t % 4 < 2,  1'b1};
      vectors++;
      if (bus.locked !== 1'b1 || bus.clk_en !== ee || bus.clk_div !== ed) begin
        miscompares++;
        $display("FAIL div0_noop t=%0d: locked %b en %b div %b expected 1 %b %b",
                 t, bus.locked, bus.clk_en, bus.clk_div, ee, ed);
      end
      tick();
    end
  endtask

  task automatic test_gating();
    int w, r;
    logic on, e1, d1;
    write_cfg(1, 4, w, r);
    for (int t = 0; t < 16; t++) begin
      if (t == 1) bus.ce[1] = 1'b0;
      if (t == 5) bus.ce[1] = 1'b1;
      on = (t < 4) || (t >= 8);
      e1 = on && (t % 4 == 3);
      d1 = on && (t % 4 < 2);
      vectors++;
      if (bus.clk_en[1] !== e1 || bus.clk_div[1] !== d1 || bus.clk_en[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL gating t=%0d: en1 %b div1 %b en0 %b expected %b %b 1",
                 t, bus.clk_en[1], bus.clk_div[1], bus.clk_en[0], e1, d1);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 2'd2;
    bus.cfg_div = 8'd3;
    vectors++;
    if (bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b expected 1", bus.cfg_ready); end
    tick();
    bus.cfg_div = 8'd2;
    n = 0;
    while (!bus.cfg_ready && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== LC) begin miscompares++; $display("FAIL held_valid_wait: got %0d expected %0d", n, LC); end
    tick();
    bus.cfg_valid = 1'b0;
    vectors++;
    if (bus.locked !== 1'b0 || bus.cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL second_accept: locked %b ready %b expected 0 0", bus.locked, bus.cfg_ready);
    end
    n = 0;
    while (!bus.locked && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== LC) begin miscompares++; $display("FAIL second_relock: got %0d expected %0d", n, LC); end
    for (int t = 0; t < 6; t++) begin
      vectors++;
      if (bus.clk_en[2] !== (t % 2 == 1) || bus.clk_div[2] !== (t % 2 == 0)) begin
        miscompares++;
        $display("FAIL ch2_div2 t=%0d: en %b div %b expected %b %b",
                 t, bus.clk_en[2], bus.clk_div[2], t % 2 == 1, t % 2 == 0);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int w, r, n;
    write_cfg(1, 4, w, r);
    tick();
    vectors++;
    if (bus.clk_div[1] !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %b expected 1", bus.clk_div[1]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.locked, bus.cfg_ready, bus.clk_en, bus.clk_div} !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got %b expected 00000000", {bus.locked, bus.cfg_ready, bus.clk_en, bus.clk_div});
    end
    n = 0;
    while (!bus.locked && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== LC || bus.clk_en !== 3'b111 || bus.clk_div !== 3'b111) begin
      miscompares++;
      $display("FAIL mid_relock: cycles %0d en %b div %b expected %0d 111 111", n, bus.clk_en, bus.clk_div, LC);
    end
  endtask

  // Reference: lock time as an absolute cycle number, phase = cycles since lock mod div.
  task automatic test_random();
    int lock_at;
    int dm [NC];
    bit ce_eff [NC];
    int run [NC];
    int ph [NC];
    bit lk, r_rst, r_val;
    int r_ch, r_dv;
    logic [NC-1:0] ee, ed;
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    tick();
    lock_at = LC;
    for (int ch = 0; ch < NC; ch++) begin dm[ch] = 1; ce_eff[ch] = 0; run[ch] = 0; end
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_val = ($urandom_range(0, 24) == 0);
      r_ch  = $urandom_range(0, 3);
      r_dv  = $urandom_range(0, 6);
      for (int ch = 0; ch < NC; ch++)
        if ($urandom_range(0, 15) == 0) bus.ce[ch] = ~bus.ce[ch];
      rst = r_rst;
      bus.cfg_valid = r_val;
      bus.cfg_ch = 2'(r_ch);
      bus.cfg_div = 8'(r_dv);

      lk = (c >= lock_at);
      for (int ch = 0; ch < NC; ch++) begin
        ph[ch] = lk ? (c - lock_at) % dm[ch] : 0;
        ee[ch] = lk && ce_eff[ch] && (ph[ch] == dm[ch] - 1);
        ed[ch] = lk && ce_eff[ch] && (ph[ch] < (dm[ch] + 1) / 2);
      end
      vectors++;
      if (bus.locked !== lk || bus.cfg_ready !== lk) begin
        miscompares++;
        $display("FAIL rand_lock c=%0d: locked %b ready %b expected %b", c, bus.locked, bus.cfg_ready, lk);
      end
      vectors++;
      if (bus.clk_en !== ee) begin
        miscompares++;
        $display("FAIL rand_en c=%0d: got %b expected %b", c, bus.clk_en, ee);
      end
      vectors++;
      if (bus.clk_div !== ed) begin
        miscompares++;
        $display("FAIL rand_div c=%0d: got %b expected %b", c, bus.clk_div, ed);
      end
      for (int ch = 0; ch < NC; ch++) begin
        if (!bus.locked) run[ch] = 0;
        else if (bus.clk_div[ch]) run[ch]++;
        else begin
          if (run[ch] > 0) begin
            vectors++;
            if (run[ch] < (dm[ch] + 1) / 2) begin
              miscompares++;
              $display("FAIL runt ch%0d c=%0d: high run %0d expected >= %0d", ch, c, run[ch], (dm[ch] + 1) / 2);
            end
          end
          run[ch] = 0;
        end
      end

      if (r_rst) begin
        lock_at = c + 1 + LC;
        for (int ch = 0; ch < NC; ch++) begin dm[ch] = 1; ce_eff[ch] = 0; end
      end else begin
        for (int ch = 0; ch < NC; ch++)
          if (!lk || ph[ch] == dm[ch] - 1) ce_eff[ch] = bus.ce[ch];
        if (lk && r_val && r_ch < NC) begin
          dm[r_ch] = (r_dv == 0) ? 1 : r_dv;
          lock_at = c + 1 + LC;
        end
      end
      tick();
    end
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_div();
    test_div_zero();
    test_gating();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/loom_clkgen_model.md
# loom_clkgen_model

Parametrised behavioural clock-generator model for simulation builds of loom_shell. It stands in for MMCM/BUFGCE_DIV-style clocking on FPGA. From one input clock it produces NUM_CH divided-clock levels and matching clock-enable pulses, with runtime-programmable divide ratios. It provides glitch-free per-channel gating and a lock indicator that models the lock delay after reset and after every reconfiguration.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (≥1)
- DIV_W, 8, divide-ratio width per channel
- LOCK_CYCLES, 64, cycles from reset release or reconfiguration to lock (≥1)

Ports:
- clk_i  input  1  sole clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- cfg_valid_i  input  1  divide-ratio write request
- cfg_ready_o  output  1  write accepted when cfg_valid_i && cfg_ready_o
- cfg_ch_i  input  max(1,$clog2(NUM_CH))  target channel
- cfg_div_i  input  DIV_W  new divide ratio; 0 is treated as 1
- ce_i  input  NUM_CH  per-channel enable request
- locked_o  output  1  outputs valid and stable
- clk_en_o  output  NUM_CH  one-cycle pulse once per divided period
- clk_div_o  output  NUM_CH  divided clock level

## Operation
- Lock FSM has two states, LOCKING and LOCKED.
  - Reset: state LOCKING, lock_cnt=0, every div register=1, every phase counter cnt=0, every ce_q=0.
  - LOCKING: lock_cnt increments each cycle. When lock_cnt==LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: hold until a config write is accepted, then go to LOCKING with lock_cnt=0.
- locked_o = (state==LOCKED). cfg_ready_o = (state==LOCKED). No writes are accepted while LOCKING.
- Accepted write:
  - div[cfg_ch_i] <= (cfg_div_i==0 ? 1 : cfg_div_i).
  - All channels' cnt are cleared, so all channels restart phase-aligned.
  - If cfg_ch_i ≥ NUM_CH, the write is still handshaked but is a no-op: no div change and no relock.
- Phase counters, per channel, only while LOCKED:
  - cnt counts 0..div-1 and wraps to 0.
  - cnt is held at 0 while LOCKING.
- Gating:
  - While LOCKING, ce_q[ch] <= ce_i[ch] every cycle.
  - While LOCKED, ce_q[ch] samples ce_i[ch] only in cycles where cnt==div-1, so an enable change takes effect at the next period boundary and never produces a runt pulse.
  - The counter free-runs regardless of ce_q.
- Outputs, per channel, derived from registered state only:
  - clk_en_o[ch] = locked_o && ce_q[ch] && cnt==div-1.
  - clk_div_o[ch] = locked_o && ce_q[ch] && cnt < ceil(div/2). The output is high for ceil(div/2) cycles and low for floor(div/2) cycles; div=1 gives a constant high.
- Simultaneous events:
  - rst_i overrides any cfg write.
  - A write accepted in the same cycle a period boundary occurs still clears cnt; the ce_q sample from that boundary is kept.
- Reset mid-operation: all state returns to reset values on the next edge. No pulse is emitted in the reset cycle or during LOCKING.

## Timing
- Output reset values: locked_o=0, cfg_ready_o=0, clk_en_o=0, clk_div_o=0.
- Let cycle 0 be the first cycle with rst_i low. locked_o first rises in cycle LOCK_CYCLES (cycle L).
- At cycle L, cnt=0. With ratio D and ce enabled, clk_en_o pulses in cycles L+D-1, L+2D-1, …
- clk_div_o rises at L and falls at L+ceil(D/2).
- A write accepted in cycle W gives locked_o=0 and cfg_ready_o=0 from W+1, and locked_o=1 again at W+1+LOCK_CYCLES.
- A ce_i change sampled at the boundary cycle B (cnt==div-1) affects outputs from B+1.

## Test plan
- Reset release, LOCK_CYCLES=8, ce_i all 1: locked_o rises at cycle 8. With default div=1, clk_en_o is all-ones and clk_div_o is all-ones from cycle 8.
- Write ch1 div=4, then ch2 div=5: after relock at L, ch1 clk_en_o pulses at L+3, L+7 and clk_div_o=1100 repeating; ch2 pulses at L+4 and clk_div_o=11100 repeating, starting at L for both channels.
- cfg_div_i=0 on ch0: behaves as div=1. A write with cfg_ch_i=NUM_CH: handshake completes, locked_o stays 1, no output change.
- With ch1 div=4, drop ce_i[1] at L+1: pulses continue through L+3, then outputs stay 0. Re-raise ce_i[1]: output resumes exactly at the next period start with a full high phase.
- cfg_valid_i held high during LOCKING: no accept until locked_o=1. Assert rst_i mid-period: all outputs 0 next cycle and relock at the LOCK_CYCLES count.
- Random cfg/ce/reset traffic against a reference model: clk_en_o and clk_div_o match cycle-exact, and no clk_div_o high run is ever shorter than ceil(div/2).
